alu_control_seq: RTL and testbench
==================================

Name: alu_control_seq

Overview:
- Parametrised successor to the single-cycle ALU opcode decoder.
- Decodes aluOp/funct7/funct3 into the 5-bit ALU opcode exactly as the single-cycle datapath does.
- Adds a sequencer for RV32M multiply/divide ops: holds the opcode, pulses a start to the multi-cycle M unit, stalls the pipeline for a parametrised latency, and flags completion.
- Sits in EX between the main control unit and the ALU/M unit.

Parameters:
- MUL_LATENCY, 2, cycles from issue to DONE for opcodes 5'b01000–5'b01011 (MUL/MULH/MULHSU/MULHU); legal range 1–63.
- DIV_LATENCY, 33, cycles from issue to DONE for opcodes 5'b01100–5'b01111 (DIV/DIVU/REM/REMU); legal range 1–63.
- DIV_ZERO_FAST, 1, when 1, a divide issued with divisorZero=1 completes with latency 1.

Ports:
- clk  input  1  system clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- funct7Parts  input  2  {funct7[6], funct7[0]}.
- funct3  input  3  instruction funct3.
- aluOp  input  2  00 ADD, 01 SUB, 10 R-type, 11 I-type.
- issueValid  input  1  EX stage holds a valid instruction this cycle.
- divisorZero  input  1  rs2 operand == 0; sampled only at issue.
- flush  input  1  synchronous kill of any in-flight M op.
- aluOpcode  output  5  opcode to ALU / M unit.
- illegalOp  output  1  R-type with funct7Parts == 2'b11.
- mdStart  output  1  one-cycle start pulse to M unit.
- mdAbort  output  1  one-cycle abort pulse to M unit.
- stall  output  1  freeze IF/ID/EX.
- mdDone  output  1  M result valid this cycle.

Behaviour:
- Decode (comb): aluOp 00 → 5'b00000; 01 → SUB; 10 → {funct7Parts, funct3}; 11 → {2'b00, funct3}.
- Illegal R-type: aluOp=10 with funct7Parts=11 → illegalOp=1, decoded opcode forced to ADD, never treated as an M op.
- M op: aluOp=10, funct7Parts=01. Latency LAT is MUL_LATENCY if funct3[2]=0, otherwise DIV_LATENCY.
- Divide-by-zero fast path: for a divide with DIV_ZERO_FAST=1 and divisorZero=1, LAT=1.
- States: IDLE, BUSY, DONE. Registers: state, opReg[4:0], cnt[5:0]. All are cleared on reset: IDLE, 0, 0.
- Reset: all outputs low except aluOpcode, which equals the combinational decode of the inputs.
- IDLE:
  - aluOpcode = decode; stall=0.
  - If issueValid, M op and !flush: mdStart=1, stall=1, opReg←decode.
  - If LAT=1 → DONE; otherwise cnt←LAT-2 and → BUSY.
  - Non-M ops complete in one cycle with no state change.
- BUSY:
  - aluOpcode=opReg; stall=1; input opcode fields are ignored.
  - If cnt=0 → DONE, else cnt←cnt-1.
- DONE:
  - aluOpcode=opReg; stall=0; mdDone=1 for exactly this cycle; → IDLE.
  - The pipeline advances this cycle. A new instruction is not issued in DONE; the next issue is examined in IDLE on the following cycle.
- Timing: issue at cycle T gives stall high for cycles T..T+LAT-1 and mdDone at T+LAT.
- flush (priority over everything):
  - In IDLE: suppresses the issue; no mdStart.
  - In BUSY: → IDLE, mdAbort=1 that cycle, stall=0, cnt←0, no mdDone.
  - In DONE: mdDone is suppressed, → IDLE, mdAbort=0 (the result is already produced).
- Async reset mid-op: immediately IDLE with all pulses low; no mdAbort is generated.
- issueValid=0 in IDLE: no state change, mdStart=0; aluOpcode still shows the decode.
- mdStart, mdAbort and mdDone are mutually exclusive in every cycle.

Test Plan:
- Reset/non-M decode: assert rstN=0 mid-stream. Then apply aluOp=10, funct7Parts=10, funct3=000 → aluOpcode=5'b10000, stall=0. Apply aluOp=11, funct3=101 → 5'b00101, stall=0.
- MUL with defaults: issue funct7Parts=01, funct3=000 at T → mdStart@T, stall T..T+1, mdDone@T+2, aluOpcode=5'b01000 throughout even if the inputs change at T+1.
- DIVU with defaults: issue funct3=101 at T → stall T..T+32, mdDone@T+33 with aluOpcode=5'b01101. Back-to-back DIVU: second mdStart no earlier than T+34.
- Divide by zero: issue REM with divisorZero=1 → mdStart@T, mdDone@T+1. Same with DIV_ZERO_FAST=0 → mdDone@T+33.
- Flush mid-DIV: flush at T+10 → mdAbort@T+10, stall=0@T+10, no mdDone. Next MUL issued at T+11 completes at T+13.
- Illegal op: aluOp=10, funct7Parts=11, issueValid=1 → illegalOp=1, aluOpcode=5'b00000, no mdStart, stall=0.

Source files
------------

// File: rtl/alu_control_seq.sv
// alu_control_seq
//   EX-stage ALU opcode decoder with a sequencer for RV32M multiply/divide.
//   Non-M ops decode combinationally and finish in one cycle. An M op latches
//   its opcode, pulses mdStart, stalls the pipeline for its latency and
//   raises mdDone for one cycle.
//
// Parameters
//   MUL_LATENCY    cycles from issue to mdDone for MUL/MULH/MULHSU/MULHU (1-63)
//   DIV_LATENCY    cycles from issue to mdDone for DIV/DIVU/REM/REMU     (1-63)
//   DIV_ZERO_FAST  1: a divide issued with divisorZero=1 completes in 1 cycle
//
// Ports
//   clk          in   system clock, rising edge
//   rstN         in   asynchronous active-low reset
//   funct7Parts  in   {funct7[6], funct7[0]}
//   funct3       in   instruction funct3
//   aluOp        in   00 ADD, 01 SUB, 10 R-type, 11 I-type
//   issueValid   in   EX stage holds a valid instruction
//   divisorZero  in   rs2 == 0, sampled only at issue
//   flush        in   synchronous kill of any in-flight M op
//   aluOpcode    out  opcode to ALU / M unit
//   illegalOp    out  R-type with funct7Parts == 2'b11
//   mdStart      out  one-cycle start pulse to the M unit
//   mdAbort      out  one-cycle abort pulse to the M unit
//   stall        out  freeze IF/ID/EX
//   mdDone       out  M result valid this cycle
module alu_control_seq #(
  parameter int unsigned MUL_LATENCY   = 2,
  parameter int unsigned DIV_LATENCY   = 33,
  parameter bit          DIV_ZERO_FAST = 1'b1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [1:0] funct7Parts,
  input  logic [2:0] funct3,
  input  logic [1:0] aluOp,
  input  logic       issueValid,
  input  logic       divisorZero,
  input  logic       flush,
  output logic [4:0] aluOpcode,
  output logic       illegalOp,
  output logic       mdStart,
  output logic       mdAbort,
  output logic       stall,
  output logic       mdDone
);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] opReg_q, opReg_d;
  logic [5:0] cnt_q, cnt_d;

  logic [4:0] decOp;
  logic       illegalDec;
  logic       isMop;
  logic [5:0] lat;

  // Combinational decode, identical to the single-cycle datapath.
  always_comb begin
    illegalDec = (aluOp == 2'b10) && (funct7Parts == 2'b11);
    isMop      = (aluOp == 2'b10) && (funct7Parts == 2'b01);
    decOp      = OP_ADD;
    unique case (aluOp)
      2'b00: decOp = OP_ADD;
      2'b01: decOp = OP_SUB;
      2'b10: decOp = illegalDec ? OP_ADD : {funct7Parts, funct3};
      2'b11: decOp = {2'b00, funct3};
      default: decOp = OP_ADD;
    endcase
  end

  // funct3[2] separates the divide group from the multiply group.
  always_comb begin
    lat = 6'(MUL_LATENCY);
    if (funct3[2]) begin
      if (DIV_ZERO_FAST && divisorZero) lat = 6'd1;
      else                              lat = 6'(DIV_LATENCY);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      opReg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opReg_q <= opReg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Issue, illegal flag and pulses are qualified with rstN so that every
  // output except aluOpcode stays low while reset is held.
  always_comb begin
    state_d   = state_q;
    opReg_d   = opReg_q;
    cnt_d     = cnt_q;
    aluOpcode = decOp;
    illegalOp = 1'b0;
    mdStart   = 1'b0;
    mdAbort   = 1'b0;
    stall     = 1'b0;
    mdDone    = 1'b0;
    unique case (state_q)
      IDLE: begin
        illegalOp = rstN && illegalDec;
        if (rstN && issueValid && isMop && !flush) begin
          mdStart = 1'b1;
          stall   = 1'b1;
          opReg_d = decOp;
          if (lat == 6'd1) begin
            state_d = DONE;
          end else begin
            cnt_d   = lat - 6'd2;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        aluOpcode = opReg_q;
        if (flush) begin
          mdAbort = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - 6'd1;
        end
      end
      DONE: begin
        aluOpcode = opReg_q;
        mdDone    = !flush;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_control_seq.sv
module tb_alu_control_seq;

  logic       clk;
  logic       rstN;
  logic [1:0] funct7Parts;
  logic [2:0] funct3;
  logic [1:0] aluOp;
  logic       issueValid;
  logic       divisorZero;
  logic       flush;

  logic [4:0] aluOpcode,  aluOpcodeN;
  logic       illegalOp,  illegalOpN;
  logic       mdStart,    mdStartN;
  logic       mdAbort,    mdAbortN;
  logic       stall,      stallN;
  logic       mdDone,     mdDoneN;

  int checks = 0;
  int errs   = 0;

  alu_control_seq dut (
    .clk(clk), .rstN(rstN), .funct7Parts(funct7Parts), .funct3(funct3),
    .aluOp(aluOp), .issueValid(issueValid), .divisorZero(divisorZero),
    .flush(flush), .aluOpcode(aluOpcode), .illegalOp(illegalOp),
    .mdStart(mdStart), .mdAbort(mdAbort), .stall(stall), .mdDone(mdDone)
  );

  alu_control_seq #(.DIV_ZERO_FAST(1'b0)) dutNf (
    .clk(clk), .rstN(rstN), .funct7Parts(funct7Parts), .funct3(funct3),
    .aluOp(aluOp), .issueValid(issueValid), .divisorZero(divisorZero),
    .flush(flush), .aluOpcode(aluOpcodeN), .illegalOp(illegalOpN),
    .mdStart(mdStartN), .mdAbort(mdAbortN), .stall(stallN), .mdDone(mdDoneN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setIn(input logic [1:0] op, input logic [1:0] f7, input logic [2:0] f3,
                       input logic iv, input logic dz, input logic fl);
    aluOp = op; funct7Parts = f7; funct3 = f3;
    issueValid = iv; divisorZero = dz; flush = fl;
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    setIn(2'b10, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0);
    // Reset: everything low, aluOpcode follows decode.
    chk("rst_opcode",  32'(aluOpcode), 32'h08);
    chk("rst_mdStart", 32'(mdStart),   32'h0);
    chk("rst_stall",   32'(stall),     32'h0);
    chk("rst_mdDone",  32'(mdDone),    32'h0);
    chk("rst_mdAbort", 32'(mdAbort),   32'h0);
    setIn(2'b10, 2'b11, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("rst_illegal", 32'(illegalOp), 32'h0);
    tick();
    rstN = 1'b1;

    // Non-M decode.
    setIn(2'b10, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("dec_rtype_sub", 32'(aluOpcode), 32'h10);
    chk("dec_rtype_stall", 32'(stall), 32'h0);
    chk("dec_rtype_start", 32'(mdStart), 32'h0);
    tick();
    setIn(2'b11, 2'b00, 3'b101, 1'b1, 1'b0, 1'b0);
    chk("dec_itype", 32'(aluOpcode), 32'h05);
    chk("dec_itype_stall", 32'(stall), 32'h0);
    tick();
    setIn(2'b00, 2'b00, 3'b111, 1'b1, 1'b0, 1'b0);
    chk("dec_add", 32'(aluOpcode), 32'h00);
    tick();
    setIn(2'b01, 2'b00, 3'b011, 1'b1, 1'b0, 1'b0);
    chk("dec_sub", 32'(aluOpcode), 32'h10);
    tick();

    // issueValid low: decode visible, no start.
    setIn(2'b10, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("noissue_opcode", 32'(aluOpcode), 32'h08);
    chk("noissue_start",  32'(mdStart),   32'h0);
    tick();
    chk("noissue_stall",  32'(stall),     32'h0);

    // MUL, latency 2.
    setIn(2'b10, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("mul_T_start",  32'(mdStart),   32'h1);
    chk("mul_T_stall",  32'(stall),     32'h1);
    chk("mul_T_opcode", 32'(aluOpcode), 32'h08);
    tick();
    setIn(2'b11, 2'b00, 3'b111, 1'b0, 1'b0, 1'b0);
    chk("mul_T1_stall",  32'(stall),     32'h1);
    chk("mul_T1_opcode", 32'(aluOpcode), 32'h08);
    chk("mul_T1_done",   32'(mdDone),    32'h0);
    chk("mul_T1_start",  32'(mdStart),   32'h0);
    tick();
    chk("mul_T2_done",   32'(mdDone),    32'h1);
    chk("mul_T2_stall",  32'(stall),     32'h0);
    chk("mul_T2_opcode", 32'(aluOpcode), 32'h08);
    tick();
    chk("mul_T3_done",   32'(mdDone),    32'h0);
    chk("mul_T3_opcode", 32'(aluOpcode), 32'h07);

    // DIVU, latency 33, issueValid held high throughout.
    setIn(2'b10, 2'b01, 3'b101, 1'b1, 1'b0, 1'b0);
    chk("divu_T_start", 32'(mdStart), 32'h1);
    chk("divu_T_stall", 32'(stall),   32'h1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("divu_T%0d_stall", k), 32'(stall),   32'h1);
      chk($sformatf("divu_T%0d_done", k),  32'(mdDone),  32'h0);
      chk($sformatf("divu_T%0d_start", k), 32'(mdStart), 32'h0);
    end
    tick();
    chk("divu_T33_done",   32'(mdDone),    32'h1);
    chk("divu_T33_opcode", 32'(aluOpcode), 32'h0D);
    chk("divu_T33_stall",  32'(stall),     32'h0);
    chk("divu_T33_start",  32'(mdStart),   32'h0);
    tick();
    // Back-to-back DIVU starts at T+34; then flushed at its T+10.
    chk("divu2_start", 32'(mdStart), 32'h1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("divu2_T%0d_stall", k), 32'(stall), 32'h1);
    end
    tick();
    setIn(2'b10, 2'b01, 3'b101, 1'b1, 1'b0, 1'b1);
    chk("flush_abort", 32'(mdAbort), 32'h1);
    chk("flush_stall", 32'(stall),   32'h0);
    chk("flush_done",  32'(mdDone),  32'h0);
    chk("flush_start", 32'(mdStart), 32'h0);
    tick();
    setIn(2'b10, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("postflush_abort", 32'(mdAbort),   32'h0);
    chk("postflush_done",  32'(mdDone),    32'h0);
    chk("postflush_start", 32'(mdStart),   32'h1);
    chk("postflush_op",    32'(aluOpcode), 32'h08);
    tick();
    setIn(2'b10, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("postflush_T12_stall", 32'(stall), 32'h1);
    tick();
    chk("postflush_T13_done", 32'(mdDone), 32'h1);
    tick();

    // Flush in IDLE suppresses the issue.
    setIn(2'b10, 2'b01, 3'b000, 1'b1, 1'b0, 1'b1);
    chk("idleflush_start", 32'(mdStart), 32'h0);
    chk("idleflush_stall", 32'(stall),   32'h0);
    tick();
    setIn(2'b10, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("idleflush_after_stall", 32'(stall), 32'h0);
    tick();

    // REM with divisor zero: fast instance done at T+1, slow at T+33.
    setIn(2'b10, 2'b01, 3'b110, 1'b1, 1'b1, 1'b0);
    chk("dz_T_start",  32'(mdStart),  32'h1);
    chk("dzN_T_start", 32'(mdStartN), 32'h1);
    tick();
    setIn(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("dz_T1_done",   32'(mdDone),    32'h1);
    chk("dz_T1_opcode", 32'(aluOpcode), 32'h0E);
    chk("dz_T1_stall",  32'(stall),     32'h0);
    chk("dzN_T1_stall", 32'(stallN),    32'h1);
    chk("dzN_T1_done",  32'(mdDoneN),   32'h0);
    for (int k = 2; k <= 32; k++) begin
      tick();
      chk($sformatf("dzN_T%0d_stall", k), 32'(stallN), 32'h1);
      chk($sformatf("dz_T%0d_done", k),   32'(mdDone),  32'h0);
    end
    tick();
    chk("dzN_T33_done",   32'(mdDoneN),    32'h1);
    chk("dzN_T33_opcode", 32'(aluOpcodeN), 32'h0E);
    tick();

    // Flush in DONE: mdDone suppressed, no abort.
    setIn(2'b10, 2'b01, 3'b011, 1'b1, 1'b0, 1'b0);
    chk("dflush_T_start", 32'(mdStart), 32'h1);
    tick();
    setIn(2'b10, 2'b01, 3'b011, 1'b0, 1'b0, 1'b0);
    tick();
    setIn(2'b10, 2'b01, 3'b011, 1'b0, 1'b0, 1'b1);
    chk("dflush_done",  32'(mdDone),    32'h0);
    chk("dflush_abort", 32'(mdAbort),   32'h0);
    chk("dflush_stall", 32'(stall),     32'h0);
    chk("dflush_op",    32'(aluOpcode), 32'h0B);
    tick();
    setIn(2'b10, 2'b01, 3'b011, 1'b0, 1'b0, 1'b0);
    chk("dflush_after_done", 32'(mdDone), 32'h0);

    // Illegal R-type.
    setIn(2'b10, 2'b11, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("ill_flag",   32'(illegalOp), 32'h1);
    chk("ill_opcode", 32'(aluOpcode), 32'h00);
    chk("ill_start",  32'(mdStart),   32'h0);
    chk("ill_stall",  32'(stall),     32'h0);
    setIn(2'b10, 2'b11, 3'b101, 1'b1, 1'b0, 1'b0);
    chk("ill_opcode_f3", 32'(aluOpcode), 32'h00);
    chk("ill_start_f3",  32'(mdStart),   32'h0);
    tick();
    setIn(2'b10, 2'b11, 3'b101, 1'b0, 1'b0, 1'b0);
    chk("ill_after_stall", 32'(stall), 32'h0);
    tick();

    // Async reset in the middle of a MUL.
    setIn(2'b10, 2'b01, 3'b001, 1'b1, 1'b0, 1'b0);
    chk("areset_T_start", 32'(mdStart), 32'h1);
    tick();
    setIn(2'b10, 2'b01, 3'b001, 1'b0, 1'b0, 1'b0);
    chk("areset_busy_stall", 32'(stall), 32'h1);
    rstN = 1'b0;
    #1;
    chk("areset_stall", 32'(stall),   32'h0);
    chk("areset_abort", 32'(mdAbort), 32'h0);
    chk("areset_done",  32'(mdDone),  32'h0);
    tick();
    rstN = 1'b1;
    #1;
    chk("areset_rel_done",  32'(mdDone), 32'h0);
    chk("areset_rel_stall", 32'(stall),  32'h0);
    tick();
    chk("areset_after_done", 32'(mdDone), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

  // Pulse exclusivity, checked every cycle away from the edge.
  always @(negedge clk) begin
    if (rstN) begin
      chk("excl", 32'(int'(mdStart) + int'(mdAbort) + int'(mdDone) <= 1), 32'h1);
    end
  end

  initial begin
    #200000;
    errs++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $fatal(1, "timeout");
  end

endmodule
